// File: rtl/seg_time_disp.sv
// rtl/seg_time_disp.sv - 6-digit multiplexed 7-segment HH.MM.SS display driver
// Snapshots time once per frame; active-low common-anode outputs with ghost blanking.
module seg_time_disp #(
  parameter int unsigned SCAN_TICKS  = 50,
  parameter int unsigned BLANK_TICKS = 2,
  parameter int unsigned LZ_BLANK    = 1,
  parameter int unsigned DP_BLINK    = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       scan_tick,
  output logic [5:0] sel,
  output logic [7:0] seg
);

  localparam logic [7:0] LAST_TICK = 8'(SCAN_TICKS - 1);
  localparam logic [7:0] BLANK_LIM = 8'(BLANK_TICKS);

  logic [2:0] idx_q, idx_d;
  logic [7:0] tick_cnt_q, tick_cnt_d;
  logic [4:0] snap_h_q, snap_h_d;
  logic [5:0] snap_m_q, snap_m_d;
  logic [5:0] snap_s_q, snap_s_d;
  logic       err_q, err_d;
  logic [5:0] sel_q, sel_d;
  logic [7:0] seg_q, seg_d;

  logic [3:0] digit;
  logic [3:0] hour_tens;
  logic [7:0] glyph_val;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 8'hC0;
      4'd1:    glyph = 8'hF9;
      4'd2:    glyph = 8'hA4;
      4'd3:    glyph = 8'hB0;
      4'd4:    glyph = 8'h99;
      4'd5:    glyph = 8'h92;
      4'd6:    glyph = 8'h82;
      4'd7:    glyph = 8'hF8;
      4'd8:    glyph = 8'h80;
      4'd9:    glyph = 8'h90;
      default: glyph = 8'hFF;
    endcase
  endfunction

  // Scan timing; the snapshot is taken only on the 5->0 wrap so a frame never tears.
  always_comb begin
    idx_d      = idx_q;
    tick_cnt_d = tick_cnt_q;
    snap_h_d   = snap_h_q;
    snap_m_d   = snap_m_q;
    snap_s_d   = snap_s_q;
    err_d      = err_q;
    if (scan_tick) begin
      if (tick_cnt_q == LAST_TICK) begin
        tick_cnt_d = 8'd0;
        if (idx_q == 3'd5) begin
          idx_d    = 3'd0;
          snap_h_d = hour;
          snap_m_d = min;
          snap_s_d = sec;
          err_d    = (hour > 5'd23) | (min > 6'd59) | (sec > 6'd59);
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        tick_cnt_d = tick_cnt_q + 8'd1;
      end
    end
  end

  assign hour_tens = 4'(snap_h_q / 5'd10);

  always_comb begin
    case (idx_q)
      3'd0:    digit = 4'(snap_s_q % 6'd10);
      3'd1:    digit = 4'(snap_s_q / 6'd10);
      3'd2:    digit = 4'(snap_m_q % 6'd10);
      3'd3:    digit = 4'(snap_m_q / 6'd10);
      3'd4:    digit = 4'(snap_h_q % 5'd10);
      3'd5:    digit = hour_tens;
      default: digit = 4'd0;
    endcase
  end

  always_comb begin
    glyph_val = glyph(digit);
    if (err_q) begin
      glyph_val = 8'hBF;
    end else if ((idx_q == 3'd5) && (LZ_BLANK != 0) && (hour_tens == 4'd0)) begin
      glyph_val = 8'hFF;
    end else if (((idx_q == 3'd2) || (idx_q == 3'd4)) &&
                 ((DP_BLINK == 0) || !snap_s_q[0])) begin
      glyph_val[7] = 1'b0;
    end
  end

  always_comb begin
    sel_d = 6'h3F;
    seg_d = 8'hFF;
    if (tick_cnt_q >= BLANK_LIM) begin
      sel_d = ~(6'b1 << idx_q);
      seg_d = glyph_val;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx_q      <= 3'd0;
      tick_cnt_q <= 8'd0;
      snap_h_q   <= 5'd0;
      snap_m_q   <= 6'd0;
      snap_s_q   <= 6'd0;
      err_q      <= 1'b0;
      sel_q      <= 6'h3F;
      seg_q      <= 8'hFF;
    end else begin
      idx_q      <= idx_d;
      tick_cnt_q <= tick_cnt_d;
      snap_h_q   <= snap_h_d;
      snap_m_q   <= snap_m_d;
      snap_s_q   <= snap_s_d;
      err_q      <= err_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule
